// File: rtl/video_to_axis_packer_pkg.sv
// Shared types and helpers for the video-to-AXI4-Stream packer.
package video_to_axis_packer_pkg;

    localparam int unsigned DEFAULT_DSIZE = 24;

    typedef enum logic [1:0] {
        IDLE,
        SOF_WAIT,
        ACTIVE,
        DROP
    } v2a_state_e;

    // Stream word as stored in the FIFO: {tuser, tlast, tdata}.
    typedef struct packed {
        logic                     user;
        logic                     last;
        logic [DEFAULT_DSIZE-1:0] data;
    } axis_word_t;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/video_to_axis_packer_fifo.sv
// Single-clock FIFO with first-word-fall-through output taken from registered storage.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign valid_o = (count_q != '0);
    // Outputs read as zero while empty so the stream side is clean out of reset.
    assign rdata_o = valid_o ? mem_q[rptr_q] : '0;
    assign do_pop  = pop_i & valid_o;
    // A pop on the same cycle frees the slot, so push into a full FIFO still lands.
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy next-state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    // Pointer and occupancy registers; reset flushes the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/video_to_axis_packer.sv
// Packs a vs/de/data video stream into AXI4-Stream video (tuser=SOF, tlast=EOL).
module video_to_axis_packer
    import video_to_axis_packer_pkg::*;
#(
    parameter int unsigned DSIZE      = DEFAULT_DSIZE,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter bit          VS_POL     = 1'b1
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic             enable,
    input  logic             vs,
    input  logic             de,
    input  logic [DSIZE-1:0] data,
    input  logic [15:0]      hactive,
    input  logic [15:0]      vactive,
    output logic [DSIZE-1:0] axis_tdata,
    output logic             axis_tvalid,
    input  logic             axis_tready,
    output logic             axis_tuser,
    output logic             axis_tlast,
    output logic             overflow,
    output logic             line_err,
    output logic             frame_err,
    output logic             frame_done
);

    v2a_state_e       state_q, state_d;
    logic             vs_act, vs_q, vs_edge_q, vs_edge_d;
    logic             hold_vld_q, hold_vld_d, hold_first_q, hold_first_d;
    logic [DSIZE-1:0] hold_data_q, hold_data_d;
    logic [15:0]      pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d, line_len;
    logic             overflow_q, overflow_d, line_err_q, line_err_d;
    logic             frame_err_q, frame_err_d, frame_done_q, frame_done_d;
    logic             cap, in_frame, push_req, push_last, push_lost, push_ok, pop_fire;
    logic             fifo_full;
    logic [DSIZE+1:0] fifo_rdata;

    assign vs_act    = VS_POL ? vs : ~vs;
    assign vs_edge_d = vs_act & ~vs_q;
    assign in_frame  = (state_q == ACTIVE) || (state_q == DROP);
    // Pixels are taken only inside an armed frame; a vs edge closes the frame first.
    assign cap       = de & ~vs_edge_q & ((state_q == SOF_WAIT) || (state_q == ACTIVE));
    assign push_req  = hold_vld_q & (state_q != DROP);
    assign push_last = ~de | vs_edge_q;
    assign pop_fire  = axis_tvalid & axis_tready;
    assign push_lost = push_req & fifo_full & ~pop_fire;
    assign push_ok   = push_req & ~push_lost;
    assign line_len  = sat_inc(pix_cnt_q);

    // Frame FSM: vs edge has priority over overflow.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (vs_edge_q && enable) state_d = SOF_WAIT;
            SOF_WAIT: begin
                if (vs_edge_q)  state_d = enable ? SOF_WAIT : IDLE;
                else if (de)    state_d = ACTIVE;
            end
            ACTIVE: begin
                if (vs_edge_q)      state_d = enable ? SOF_WAIT : IDLE;
                else if (push_lost) state_d = DROP;
            end
            DROP:     if (vs_edge_q) state_d = enable ? SOF_WAIT : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Hold stage, geometry counters and sticky flags.
    always_comb begin
        hold_vld_d   = cap;
        hold_first_d = cap ? (state_q == SOF_WAIT) : hold_first_q;
        hold_data_d  = cap ? data : hold_data_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        line_err_d   = line_err_q;
        frame_err_d  = frame_err_q;
        overflow_d   = overflow_q | push_lost;
        frame_done_d = 1'b0;
        if (push_ok) begin
            if (push_last) begin
                pix_cnt_d  = '0;
                line_cnt_d = sat_inc(line_cnt_q);
                if (line_len != hactive) line_err_d = 1'b1;
            end else begin
                pix_cnt_d = line_len;
            end
        end
        // line_cnt_d already includes a last pushed on the edge cycle itself.
        if (vs_edge_q) begin
            if (in_frame) begin
                frame_done_d = 1'b1;
                if (line_cnt_d != vactive) frame_err_d = 1'b1;
            end
            pix_cnt_d  = '0;
            line_cnt_d = '0;
        end
    end

    // State registers; vs_q resets high so a vs already active at release is not an edge.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q      <= IDLE;
            vs_q         <= 1'b1;
            vs_edge_q    <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_first_q <= 1'b0;
            hold_data_q  <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vs_act;
            vs_edge_q    <= vs_edge_d;
            hold_vld_q   <= hold_vld_d;
            hold_first_q <= hold_first_d;
            hold_data_q  <= hold_data_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            overflow_q   <= overflow_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    axis_sync_fifo #(
        .WIDTH (DSIZE + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (pclk),
        .rst_i   (prst),
        .push_i  (push_req),
        .wdata_i ({hold_first_q, push_last, hold_data_q}),
        .full_o  (fifo_full),
        .pop_i   (axis_tready),
        .valid_o (axis_tvalid),
        .rdata_o (fifo_rdata)
    );

    assign {axis_tuser, axis_tlast, axis_tdata} = fifo_rdata;
    assign overflow   = overflow_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;
    assign frame_done = frame_done_q;

endmodule
